// File: rtl/vga_scan_controller.sv
// 640x480@60 VGA scan timing with a framebuffer time-shared between scan-out reads
// (even clk) and requester writes (odd clk). Write arbitration exists only when VGA_WRITE_ARB_EN is defined.
module vga_scan_controller #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int H_TOTAL       = 800,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int V_TOTAL       = 525
) (
  input  logic        clk,
  input  logic        reset,
  output logic        vga_clk,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [9:0]  red,
  output logic [9:0]  green,
  output logic [9:0]  blue,
  output logic        frame_start,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wdata,
  input  logic [3:0]  mem_rdata,
  input  logic        wr_req,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [3:0]  wr_data,
  output logic        wr_ack
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FRONT_PORCH);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FRONT_PORCH + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FRONT_PORCH);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FRONT_PORCH + V_SYNC - 1);
  // back porches are implied by the totals
  localparam int unused_back_porch = H_BACK_PORCH + V_BACK_PORCH;

  logic       ph_q, ph_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
  logic [2:0] rgb_q, rgb_d;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap, v_wrap, scan_active;

  // 19-bit sums wrap identically to the 20-bit sum truncated to 19 bits
  function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
    return {y, 9'b0} + {2'b0, y, 7'b0} + {9'b0, x};
  endfunction

  assign h_wrap      = (h_q == H_LAST);
  assign v_wrap      = (v_q == V_LAST);
  assign scan_active = (h_q < H_ACT) && (v_q < V_ACT);

  always_comb begin
    ph_d          = ~ph_q;
    h_d           = h_q;
    v_d           = v_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    rgb_d         = rgb_q;
    frame_start_d = 1'b0;
    if (ph_q) begin
      h_d           = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      frame_start_d = h_wrap && v_wrap;
      hsync_d       = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
      vsync_d       = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
      blank_d       = scan_active;
      rgb_d         = scan_active ? mem_rdata[2:0] : 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q          <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      ph_q          <= ph_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_clk     = ph_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign red         = {10{rgb_q[2]}};
  assign green       = {10{rgb_q[1]}};
  assign blue        = {10{rgb_q[0]}};
  assign frame_start = frame_start_q;

`ifdef VGA_WRITE_ARB_EN
  logic wr_in_range;
  logic unused_rdata;
  assign wr_in_range  = (wr_x < H_ACT) && (wr_y < V_ACT);
  assign unused_rdata = mem_rdata[3];
`else
  logic unused_inputs;
  assign unused_inputs = ^{mem_rdata[3], wr_req, wr_x, wr_y, wr_data};
`endif

  // reset gates the write slot so a write in flight at reset never lands
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    if (!ph_q) begin
      if (scan_active) mem_addr = pix_addr(h_q, v_q);
    end
`ifdef VGA_WRITE_ARB_EN
    else if (wr_req && !reset) begin
      wr_ack = 1'b1;
      if (wr_in_range) begin
        mem_addr  = pix_addr(wr_x, wr_y);
        mem_we    = 1'b1;
        mem_wdata = wr_data;
      end
    end
`endif
  end

endmodule

// File: doc/vga_scan_controller.md
# vga_scan_controller

Generates 640x480@60 VGA timing and scans a single-port 4-bit framebuffer, driving `vga_clk`, `hsync`, `vsync`, `blank` and 10-bit RGB into the VGA capture interface of the DESim simulation. Time-multiplexes that framebuffer between scan-out reads and a drawing requester's writes. `clk` runs at twice the pixel rate: even cycles are the read slot, odd cycles are the write slot.

## Interface
Parameters:
- `H_ACTIVE`, 640, active pixels per line
- `H_FRONT_PORCH`, 16, pixels
- `H_SYNC`, 96, pixels
- `H_BACK_PORCH`, 48, pixels
- `H_TOTAL`, 800, sum of the four horizontal parameters
- `V_ACTIVE`, 480, active lines per frame
- `V_FRONT_PORCH`, 10, lines
- `V_SYNC`, 2, lines
- `V_BACK_PORCH`, 33, lines
- `V_TOTAL`, 525, sum of the four vertical parameters

Ports:
- `clk`  in  1  system clock, 2x pixel rate
- `reset`  in  1  synchronous, active-high
- `vga_clk`  out  1  pixel clock, equals the phase register `ph`
- `hsync`, `vsync`  out  1 each  active-low sync
- `blank`  out  1  high during active video (DE2 `BLANK_N` convention)
- `red`, `green`, `blue`  out  10 each  pixel colour
- `frame_start`  out  1  one-`clk` pulse when the scan counters wrap to (0,0)
- `mem_addr`  out  19  framebuffer address
- `mem_we`  out  1  framebuffer write strobe
- `mem_wdata`  out  4  framebuffer write data
- `mem_rdata`  in  4  framebuffer read data, synchronous, 1-`clk` latency
- `wr_req`  in  1  requester write request
- `wr_x`  in  10  write pixel column
- `wr_y`  in  10  write pixel row
- `wr_data`  in  4  write pixel value
- `wr_ack`  out  1  write accepted this cycle

## Operation
- `ph` toggles every `clk`. `ph=0` is the read slot; `ph=1` is the write slot.
- Counters `h` (0..H_TOTAL-1) and `v` (0..V_TOTAL-1) advance on every `clk` edge where `ph=1`.
  - `h` wraps to 0 and increments `v`.
  - `v` wraps to 0 at V_TOTAL-1.
- Horizontal regions: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical regions: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Address arithmetic: `addr = {y,9'b0} + {y,7'b0} + x`, computed 20 bits wide and truncated to 19. Maximum in-range value is 307199.
- Read slot (`ph=0`):
  - If `h<640` and `v<480`: `mem_addr = addr(h,v)`, `mem_we=0`.
  - Otherwise: `mem_addr = 0`, `mem_we=0`.
- Write slot (`ph=1`), arbitration enabled:
  - If `wr_req=1`, then `wr_ack=1` combinationally in the same cycle.
  - If `wr_x<640` and `wr_y<480`: `mem_addr = addr(wr_x,wr_y)`, `mem_we=1`, `mem_wdata = wr_data`.
  - If the write is out of range, it is acked and dropped (`mem_we=0`).
- Requester handshake: hold `wr_req`, `wr_x`, `wr_y` and `wr_data` stable until `wr_ack`. A held request is served once per write slot, so back-to-back writes are accepted every 2 `clk`.
- `wr_ack` and `mem_we` are never high in a `ph=0` cycle.
- Video register update, on the `clk` edge ending `ph=1`, using the current (pre-increment) `h` and `v`:
  - `hsync = !(656<=h<=751)`
  - `vsync = !(490<=v<=491)`
  - `blank = (h<640 && v<480)`
  - If active: `red = {10{mem_rdata[2]}}`, `green = {10{mem_rdata[1]}}`, `blue = {10{mem_rdata[0]}}`. `mem_rdata[3]` is ignored.
  - If not active: RGB = 0.
- `frame_start` is registered. It pulses high for the one `clk` following the edge where (h,v) wraps from (799,524) to (0,0).

## Timing
- Reset values:
  - `ph=0`, `h=0`, `v=0`
  - `vga_clk=0`, `hsync=1`, `vsync=1`, `blank=0`
  - RGB = 0, `frame_start=0`
  - `mem_we=0`, `wr_ack=0`, `mem_addr=0`
- Reset mid-frame: every value above is restored on the next edge; any in-flight write is not performed.
- Read latency:
  - Address for pixel (h,v) is presented in `ph=0` cycle N.
  - `mem_rdata` is valid in cycle N+1 (`ph=1`).
  - RGB, `blank` and syncs for (h,v) update together at the end of N+1.
  - `vga_clk` rises one `clk` later, so the sink samples stable data.
- One pixel = 2 `clk`; one line = 1600 `clk`; one frame = 840000 `clk`.
- `wr_req` asserted in a `ph=0` cycle waits exactly 1 `clk`. Worst-case ack latency is 1 `clk`.

## Configuration
- `VGA_WRITE_ARB_EN` defined: the write slot serves `wr_req` as described in Operation.
- Not defined:
  - `wr_*` inputs are ignored.
  - `wr_ack` is tied 0 and `mem_we` is tied 0.
  - `mem_addr` is driven only by the read slot (0 in write slots).
  - Scan timing is identical in both builds.

## Test plan
- Reset then run 840000 `clk` -> hsync low 192 `clk` per line starting at clk `1+2*656` of each line; vsync low for 3200 `clk`; `frame_start` pulses once at `clk` 840000.
- Preload `mem[0]=4'h4`, `mem[639]=4'h1`, `mem[307199]=4'h2` -> at (0,0) `red=10'h3FF`, `green=0`, `blue=0`; at (639,0) only `blue=10'h3FF`; at (639,479) only `green=10'h3FF`; `blank=0` and RGB=0 at (640,0).
- Hold `wr_req=1`, `wr_x=5`, `wr_y=2`, `wr_data=4'h7`, starting in a `ph=0` cycle -> `wr_ack` and `mem_we` high in the next cycle only, with `mem_addr=1285`; no ack in the preceding `ph=0` cycle.
- Write with `wr_x=640`, `wr_y=0` -> `wr_ack=1`, `mem_we=0`.
- Assert `reset` at `h=300`, `v=200` -> next cycle `hsync=1`, `vsync=1`, `blank=0`, RGB=0, `vga_clk=0`; scan restarts from (0,0).
- Build without `VGA_WRITE_ARB_EN`, `wr_req=1` for 10 `clk` -> `wr_ack=0` and `mem_we=0` throughout; video output unchanged.
